univ_shift_reg: RTL and testbench
=================================

// Module: univ_shift_reg
// PURPOSE
//   Parametrised universal register: parallel load, hold, clear, logical shift and rotate in
//   both directions, plus a counted burst-shift mode that streams bits out serially.
//   Sits between the memory data path and the CRC engine.
//   Words are parked here or serialised LSB-first into the CRC shifter.
// PARAMETERS
//   WIDTH      8    register width in bits (>=2)
//   RESET_VAL  0    value of q after reset (WIDTH bits)
//   CW         $clog2(WIDTH+1)  burst count width (localparam, not overridable)
// PORTS
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   mode       in   3       operation select (table below), sampled each rising edge
//   load_data  in   WIDTH   parallel data for LOAD
//   ser_in_l   in   1       serial bit entering MSB on right shift / burst
//   ser_in_r   in   1       serial bit entering LSB on left shift
//   shift_cnt  in   CW      burst length, sampled with mode==BURST
//   q          out  WIDTH   register contents
//   ser_out_r  out  1       q[0] (combinational from q)
//   ser_out_l  out  1       q[WIDTH-1] (combinational from q)
//   busy       out  1       burst in progress
//   done       out  1       one-cycle pulse, burst finished
// BEHAVIOUR
//   Reset (rst_n=0, async): q=RESET_VAL, busy=0, done=0, FSM=IDLE, remaining count=0.
//   Outputs are held for as long as rst_n is low.
//   Reset asserted mid-burst aborts the burst immediately; no done pulse is produced.
//   Mode table (IDLE only, effect at the sampling edge):
//     000 HOLD   q unchanged
//     001 LOAD   q <= load_data
//     010 SHR    q <= {ser_in_l, q[WIDTH-1:1]}
//     011 SHL    q <= {q[WIDTH-2:0], ser_in_r}
//     100 ROR    q <= {q[0], q[WIDTH-1:1]}
//     101 ROL    q <= {q[WIDTH-2:0], q[WIDTH-1]}
//     110 CLR    q <= 0 (not RESET_VAL)
//     111 BURST  start counted right shift (FSM)
//   FSM states: IDLE, BURST.
//   IDLE, mode=111, N=min(shift_cnt,WIDTH):
//     N==0: stay IDLE; q unchanged; done=1 for the next cycle; busy stays 0.
//     N>0:  go to BURST; rem<=N; busy=1; q unchanged at this edge.
//   BURST, each edge: q <= {ser_in_l, q[WIDTH-1:1]}; rem<=rem-1.
//     On the edge where rem goes 1->0: go to IDLE, busy<=0, done<=1 for exactly one cycle.
//     Burst of N shifts therefore takes N+1 edges from the command edge to the done edge.
//   While busy=1, mode, load_data and shift_cnt are ignored. ser_in_l is still sampled every edge.
//   A new command can be sampled on the same edge at which done rises (back-to-back bursts allowed).
//   shift_cnt>WIDTH saturates to WIDTH.
//   done and busy are never both 1.
//   Every edge that does not end a burst, and every edge in IDLE other than BURST with N==0, drives done to 0.
// CONFIGURATION
//   PARITY_EN defined: adds output parity (1 bit), registered and equal to ^q at all times, including reset.
//   parity is updated on the same edge as q, so there is no extra latency.
//   PARITY_EN undefined: no parity port, no parity logic.
// TESTING
//   1. rst_n=0 with RESET_VAL=8'hA5 -> q=A5, busy=0, done=0. Assert rst_n=0 mid-burst -> same values, no done pulse.
//   2. LOAD 8'h3C, then SHR with ser_in_l=1 -> q=9E. SHL with ser_in_r=0 -> q=3C. ROR -> 1E. ROL -> 3C. CLR -> 00.
//   3. LOAD 8'hB1, BURST shift_cnt=3, ser_in_l=0 -> busy high 3 cycles; ser_out_r sequence 1,0,0; q=16; done pulse on 4th edge.
//   4. BURST shift_cnt=0 -> done=1 for one cycle, busy=0, q unchanged.
//      BURST shift_cnt=15 (WIDTH=8) -> 8 shifts only.
//   5. During busy drive mode=001 with load_data=FF -> ignored, q keeps shifting.
//      Issue BURST on the done edge -> second burst starts with no gap.
//   6. PARITY_EN: LOAD 8'h07 -> parity=1. SHL with ser_in_r=1 (q=0F) -> parity=0.

Source files
------------

// File: rtl/univ_shift_reg_if.sv
// ============================================================================
// univ_shift_reg_if : command/data bundle for the universal shift register
// (PARITY_EN adds the parity output). Revision 1.0
// ============================================================================
`default_nettype none

interface univ_shift_reg_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2:0]       mode;
  logic [WIDTH-1:0] load_data;
  logic             ser_in_l;
  logic             ser_in_r;
  logic [CW-1:0]    shift_cnt;
  logic [WIDTH-1:0] q;
  logic             ser_out_r;
  logic             ser_out_l;
  logic             busy;
  logic             done;
`ifdef PARITY_EN
  logic             parity;

  modport master (
    output mode, load_data, ser_in_l, ser_in_r, shift_cnt,
    input  q, ser_out_r, ser_out_l, busy, done, parity
  );
  modport slave (
    input  mode, load_data, ser_in_l, ser_in_r, shift_cnt,
    output q, ser_out_r, ser_out_l, busy, done, parity
  );
`else
  modport master (
    output mode, load_data, ser_in_l, ser_in_r, shift_cnt,
    input  q, ser_out_r, ser_out_l, busy, done
  );
  modport slave (
    input  mode, load_data, ser_in_l, ser_in_r, shift_cnt,
    output q, ser_out_r, ser_out_l, busy, done
  );
`endif
endinterface

`default_nettype wire

// File: rtl/univ_shift_reg.sv
// ============================================================================
// univ_shift_reg : universal register (load/hold/clear/shift/rotate) with a
// counted LSB-first burst mode; optional PARITY_EN output. Revision 1.0
// ============================================================================
`default_nettype none

module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  wire              clk,
  input  wire              rst_n,
  univ_shift_reg_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHR   = 3'b010;
  localparam logic [2:0] M_SHL   = 3'b011;
  localparam logic [2:0] M_ROR   = 3'b100;
  localparam logic [2:0] M_ROL   = 3'b101;
  localparam logic [2:0] M_CLR   = 3'b110;
  localparam logic [2:0] M_BURST = 3'b111;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_reg, q_nxt;
  logic [CW-1:0]    rem, rem_nxt;
  logic             done_reg, done_nxt;
  logic [CW-1:0]    burst_len;

  assign burst_len = (bus.shift_cnt > CW'(WIDTH)) ? CW'(WIDTH) : bus.shift_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      q_reg    <= RESET_VAL;
      rem      <= '0;
      done_reg <= 1'b0;
    end else begin
      state    <= state_nxt;
      q_reg    <= q_nxt;
      rem      <= rem_nxt;
      done_reg <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q_reg;
    rem_nxt   = rem;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        case (bus.mode)
          M_HOLD:  q_nxt = q_reg;
          M_LOAD:  q_nxt = bus.load_data;
          M_SHR:   q_nxt = {bus.ser_in_l, q_reg[WIDTH-1:1]};
          M_SHL:   q_nxt = {q_reg[WIDTH-2:0], bus.ser_in_r};
          M_ROR:   q_nxt = {q_reg[0], q_reg[WIDTH-1:1]};
          M_ROL:   q_nxt = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
          M_CLR:   q_nxt = '0;
          M_BURST: begin
            // A zero-length burst completes immediately without entering BURST.
            if (burst_len == '0) begin
              done_nxt = 1'b1;
            end else begin
              state_nxt = S_BURST;
              rem_nxt   = burst_len;
            end
          end
          default: q_nxt = q_reg;
        endcase
      end
      S_BURST: begin
        q_nxt   = {bus.ser_in_l, q_reg[WIDTH-1:1]};
        rem_nxt = rem - 1'b1;
        if (rem == CW'(1)) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.q         = q_reg;
  assign bus.ser_out_r = q_reg[0];
  assign bus.ser_out_l = q_reg[WIDTH-1];
  assign bus.busy      = (state == S_BURST);
  assign bus.done      = done_reg;

`ifdef PARITY_EN
  logic parity_reg;

  // Registered from the next value so parity tracks q with no added latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_reg <= ^RESET_VAL;
    else        parity_reg <= ^q_nxt;
  end

  assign bus.parity = parity_reg;
`endif

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
// ============================================================================
// tb_univ_shift_reg : vector table, corner sequences and randomized run
// against a reference model of univ_shift_reg. Revision 1.0
// ============================================================================
`default_nettype none

module tb_univ_shift_reg;
  localparam int         W  = 8;
  localparam int         CW = $clog2(W + 1);
  localparam logic [7:0] RV = 8'hA5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  univ_shift_reg_if #(.WIDTH(W)) bus ();

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: register value, remaining burst shifts, done flag.
  logic [W-1:0] mq;
  int           mrem;
  logic         mdone;

  typedef struct {
    logic [2:0] mode;
    logic [7:0] ld;
    logic       sl;
    logic       sr;
    logic [3:0] cnt;
    logic [7:0] exp_q;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic model_reset();
    mq = RV; mrem = 0; mdone = 1'b0;
  endtask

  task automatic model_step(input logic [2:0] m, input logic [7:0] ld,
                            input logic sl, input logic sr, input logic [3:0] cnt);
    int n;
    if (mrem > 0) begin
      mq    = (mq >> 1) | (W'(sl) << (W - 1));
      mrem  = mrem - 1;
      mdone = (mrem == 0);
    end else begin
      mdone = 1'b0;
      case (m)
        3'd0: mq = mq;
        3'd1: mq = ld;
        3'd2: mq = (mq >> 1) | (W'(sl) << (W - 1));
        3'd3: mq = (mq << 1) | W'(sr);
        3'd4: mq = (mq >> 1) | (W'(mq[0]) << (W - 1));
        3'd5: mq = (mq << 1) | W'(mq[W-1]);
        3'd6: mq = '0;
        default: begin
          n = (int'(cnt) > W) ? W : int'(cnt);
          if (n == 0) mdone = 1'b1;
          else        mrem  = n;
        end
      endcase
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".q"},     32'(bus.q),         32'(mq));
    check({tag, ".busy"},  32'(bus.busy),      32'(mrem > 0));
    check({tag, ".done"},  32'(bus.done),      32'(mdone));
    check({tag, ".sor"},   32'(bus.ser_out_r), 32'(mq[0]));
    check({tag, ".sol"},   32'(bus.ser_out_l), 32'(mq[W-1]));
`ifdef PARITY_EN
    check({tag, ".par"},   32'(bus.parity),    32'(^mq));
`endif
  endtask

  // Drive inputs (called at a negedge), clock once, advance the model.
  task automatic tick(input logic [2:0] m, input logic [7:0] ld,
                      input logic sl, input logic sr, input logic [3:0] cnt);
    bus.mode = m; bus.load_data = ld; bus.ser_in_l = sl;
    bus.ser_in_r = sr; bus.shift_cnt = CW'(cnt);
    @(posedge clk);
    model_step(m, ld, sl, sr, cnt);
    @(negedge clk);
  endtask

  int cyc;

  initial begin
    bus.mode = 3'd0; bus.load_data = '0; bus.ser_in_l = 1'b0;
    bus.ser_in_r = 1'b0; bus.shift_cnt = '0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.q",    32'(bus.q),    32'h A5);
    check("rst.busy", 32'(bus.busy), 32'h0);
    check("rst.done", 32'(bus.done), 32'h0);
`ifdef PARITY_EN
    check("rst.par",  32'(bus.parity), 32'(^RV));
`endif
    rst_n = 1'b1;

    // Directed vector table
    //               mode  ld     sl sr cnt  q     busy done
    vecs.push_back('{3'd1, 8'h3C, 0, 0, 0, 8'h3C, 0, 0});
    vecs.push_back('{3'd2, 8'h00, 1, 0, 0, 8'h9E, 0, 0});
    vecs.push_back('{3'd3, 8'h00, 0, 0, 0, 8'h3C, 0, 0});
    vecs.push_back('{3'd4, 8'h00, 0, 0, 0, 8'h1E, 0, 0});
    vecs.push_back('{3'd5, 8'h00, 0, 0, 0, 8'h3C, 0, 0});
    vecs.push_back('{3'd6, 8'h00, 0, 0, 0, 8'h00, 0, 0});
    vecs.push_back('{3'd1, 8'hB1, 0, 0, 0, 8'hB1, 0, 0});
    vecs.push_back('{3'd7, 8'h00, 0, 0, 3, 8'hB1, 1, 0});
    vecs.push_back('{3'd0, 8'h00, 0, 0, 0, 8'h58, 1, 0});
    vecs.push_back('{3'd0, 8'h00, 0, 0, 0, 8'h2C, 1, 0});
    vecs.push_back('{3'd0, 8'h00, 0, 0, 0, 8'h16, 0, 1});
    vecs.push_back('{3'd0, 8'h00, 0, 0, 0, 8'h16, 0, 0});
    vecs.push_back('{3'd7, 8'h00, 0, 0, 0, 8'h16, 0, 1});
    vecs.push_back('{3'd0, 8'h00, 0, 0, 0, 8'h16, 0, 0});
    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].mode, vecs[i].ld, vecs[i].sl, vecs[i].sr, vecs[i].cnt);
      check($sformatf("vec%0d.q", i),    32'(bus.q),    32'(vecs[i].exp_q));
      check($sformatf("vec%0d.busy", i), 32'(bus.busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d.done", i), 32'(bus.done), 32'(vecs[i].exp_done));
    end

    // Burst serial output 1,0,0 observed on ser_out_r while busy
    tick(3'd1, 8'hB1, 0, 0, 0);
    tick(3'd7, 8'h00, 0, 0, 3);
    check("ser.b0", 32'(bus.ser_out_r), 32'h1);
    tick(3'd0, 8'h00, 0, 0, 0);
    check("ser.b1", 32'(bus.ser_out_r), 32'h0);
    tick(3'd0, 8'h00, 0, 0, 0);
    check("ser.b2", 32'(bus.ser_out_r), 32'h0);
    tick(3'd0, 8'h00, 0, 0, 0);
    check_model("ser.end");

    // Saturation: shift_cnt=15 gives exactly 8 shifts
    tick(3'd1, 8'h81, 0, 0, 0);
    tick(3'd7, 8'h00, 1, 0, 15);
    cyc = 1;
    while (bus.busy && cyc < 20) begin
      tick(3'd0, 8'h00, 1, 0, 0);
      cyc++;
    end
    check("sat.edges", 32'(cyc), 32'd9);
    check("sat.q",     32'(bus.q), 32'hFF);
    check("sat.done",  32'(bus.done), 32'h1);

    // Commands ignored while busy, then back-to-back burst from the done cycle
    tick(3'd1, 8'h5A, 0, 0, 0);
    tick(3'd7, 8'h00, 1, 0, 4);
    for (int i = 0; i < 4; i++) begin
      tick(3'd1, 8'hFF, logic'(i[0]), 0, 0);
      check_model($sformatf("ign%0d", i));
    end
    check("b2b.done", 32'(bus.done), 32'h1);
    tick(3'd7, 8'h00, 0, 0, 2);
    check("b2b.busy", 32'(bus.busy), 32'h1);
    check_model("b2b");
    tick(3'd0, 8'h00, 1, 0, 0);
    tick(3'd0, 8'h00, 1, 0, 0);
    check_model("b2b.end");

`ifdef PARITY_EN
    tick(3'd1, 8'h07, 0, 0, 0);
    check("par.07", 32'(bus.parity), 32'h1);
    tick(3'd3, 8'h00, 0, 1, 0);
    check("par.0F", 32'(bus.parity), 32'h0);
`endif

    // Reset mid-burst aborts without a done pulse
    tick(3'd1, 8'h3C, 0, 0, 0);
    tick(3'd7, 8'h00, 1, 0, 5);
    tick(3'd0, 8'h00, 1, 0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("mrst.q",    32'(bus.q),    32'hA5);
    check("mrst.busy", 32'(bus.busy), 32'h0);
    check("mrst.done", 32'(bus.done), 32'h0);
    repeat (3) begin
      @(negedge clk);
      check_model("mrst.hold");
    end
    rst_n = 1'b1;
    tick(3'd0, 8'h00, 0, 0, 0);
    check_model("mrst.after");

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      tick(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'($urandom),
           4'($urandom_range(0, 15)));
      check_model("rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
